// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM between the fetch stage (read only) and the
// memory stage (read/write). One requester is served at a time. The memory
// stage wins simultaneous requests because it holds the older instruction.
//
// Handshake (both ports): a requester raises req_i with its fields and keeps
// them stable until it sees a one-cycle done_o pulse. rdata_o and error_o are
// only meaningful while done_o is high and read as 0 otherwise. Fields are
// latched at grant, so later changes are ignored. A req_i that is dropped
// after grant does not cancel the access; done_o still pulses.
// stall_o = req_i && !done_o.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   m_req_i/m_we_i          memory-stage request, write (1) / read (0)
//   m_addr_i/m_wdata_i      memory-stage byte address, write data
//   m_done_o/m_rdata_o      memory-stage completion pulse, read data
//   m_error_o/m_stall_o     memory-stage address error, stall
//   f_req_i/f_addr_i        fetch read request, byte address
//   f_done_o/f_rdata_o      fetch completion pulse, read data
//   f_error_o/f_stall_o     fetch address error, stall
//   ram_r_en_o/ram_w_en_o   RAM read/write enables
//   ram_addr_o/ram_wdata_o  RAM address and write data
//   ram_rdata_i             RAM read data, valid in the last ACCESS cycle
//   busy_o                  FSM is not idle
//   dbg_state_o             current FSM state (IDLE=0, ACCESS=1, RESP=2)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_LAT   = 2,
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m_req_i,
  input  logic        m_we_i,
  input  logic [63:0] m_addr_i,
  input  logic [63:0] m_wdata_i,
  output logic        m_done_o,
  output logic [63:0] m_rdata_o,
  output logic        m_error_o,
  output logic        m_stall_o,

  input  logic        f_req_i,
  input  logic [63:0] f_addr_i,
  output logic        f_done_o,
  output logic [63:0] f_rdata_o,
  output logic        f_error_o,
  output logic        f_stall_o,

  output logic        ram_r_en_o,
  output logic        ram_w_en_o,
  output logic [63:0] ram_addr_o,
  output logic [63:0] ram_wdata_o,
  input  logic [63:0] ram_rdata_i,

  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  // Counter only has to hold MEM_LAT-1.
  localparam int          CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  // Highest legal word address; a full 64-bit compare avoids any wrap.
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e         state_q;
  logic           grant_f_q;   // 1: fetch owns the current access
  logic           we_q;
  logic           err_q;
  logic           done_q;
  logic [63:0]    rdata_q;
  logic [CW-1:0]  cnt_q;
  logic           ram_r_en_q;
  logic           ram_w_en_q;
  logic [63:0]    ram_addr_q;
  logic [63:0]    ram_wdata_q;

  // Grant-side selection: fixed priority to the memory stage.
  logic           sel_f_d;
  logic           sel_we_d;
  logic [63:0]    sel_addr_d;
  logic [63:0]    sel_wdata_d;
  logic           range_err_d;

  always_comb begin
    sel_f_d     = ~m_req_i;
    sel_we_d    = m_req_i ? m_we_i    : 1'b0;
    sel_addr_d  = m_req_i ? m_addr_i  : f_addr_i;
    sel_wdata_d = m_req_i ? m_wdata_i : 64'd0;
    range_err_d = (sel_addr_d > MAX_ADDR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      grant_f_q   <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 64'd0;
      cnt_q       <= '0;
      ram_r_en_q  <= 1'b0;
      ram_w_en_q  <= 1'b0;
      ram_addr_q  <= 64'd0;
      ram_wdata_q <= 64'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m_req_i || f_req_i) begin
            grant_f_q <= sel_f_d;
            we_q      <= sel_we_d;
            err_q     <= range_err_d;
            rdata_q   <= 64'd0;
            if (range_err_d) begin
              // Bad address: answer immediately, the RAM is never touched.
              state_q <= S_RESP;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_ACCESS;
              cnt_q       <= CNT_LOAD;
              ram_addr_q  <= sel_addr_d;
              ram_r_en_q  <= ~sel_we_d;
              ram_w_en_q  <= sel_we_d;
              ram_wdata_q <= sel_we_d ? sel_wdata_d : 64'd0;
            end
          end
        end

        S_ACCESS: begin
          // A write strobe lasts exactly the first ACCESS cycle.
          ram_w_en_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            rdata_q     <= we_q ? 64'd0 : ram_rdata_i;
            ram_r_en_q  <= 1'b0;
            ram_addr_q  <= 64'd0;
            ram_wdata_q <= 64'd0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Responses are steered to the granted port; the other port reads 0.
  assign m_done_o    = done_q & ~grant_f_q;
  assign f_done_o    = done_q &  grant_f_q;
  assign m_rdata_o   = m_done_o ? rdata_q : 64'd0;
  assign f_rdata_o   = f_done_o ? rdata_q : 64'd0;
  assign m_error_o   = m_done_o & err_q;
  assign f_error_o   = f_done_o & err_q;
  assign m_stall_o   = m_req_i & ~m_done_o;
  assign f_stall_o   = f_req_i & ~f_done_o;

  assign ram_r_en_o  = ram_r_en_q;
  assign ram_w_en_o  = ram_w_en_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int          L    = 2;
  localparam int          MB   = 1024;
  localparam logic [63:0] MAXA = 64'(MB - 8);
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_req, m_we, f_req;
  logic [63:0] m_addr, m_wdata, f_addr;
  logic        m_done_o, m_error_o, m_stall_o, f_done_o, f_error_o, f_stall_o;
  logic [63:0] m_rdata_o, f_rdata_o;
  logic        ram_r_en_o, ram_w_en_o, busy_o;
  logic [63:0] ram_addr_o, ram_wdata_o;
  logic [63:0] ram_rdata_i;
  logic [1:0]  dbg_state_o;

  dmem_arbiter #(.MEM_LAT(L), .MEM_BYTES(MB)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_done_o(m_done_o), .m_rdata_o(m_rdata_o), .m_error_o(m_error_o), .m_stall_o(m_stall_o),
    .f_req_i(f_req), .f_addr_i(f_addr),
    .f_done_o(f_done_o), .f_rdata_o(f_rdata_o), .f_error_o(f_error_o), .f_stall_o(f_stall_o),
    .ram_r_en_o(ram_r_en_o), .ram_w_en_o(ram_w_en_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ------------------------------------------------------------ RAM model
  // Word-indexed RAM, cleared while rst is high. Read data is only correct in
  // the L-th consecutive read-enable cycle, so early capture shows up.
  logic [63:0] ram_mem [0:MB/8-1];
  logic        pre_en;
  logic [63:0] pre_addr, pre_data;
  int          rcnt;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MB/8; i++) ram_mem[i] <= 64'd0;
    end else if (pre_en) begin
      ram_mem[pre_addr[9:3]] <= pre_data;
    end else if (ram_w_en_o) begin
      ram_mem[ram_addr_o[9:3]] <= ram_wdata_o;
    end
  end

  always @(negedge clk) begin
    rcnt        <= ram_r_en_o ? rcnt + 1 : 0;
    ram_rdata_i <= !ram_r_en_o ? 64'd0 :
                   (rcnt == L - 1) ? ram_mem[ram_addr_o[9:3]] : JUNK;
  end

  // ------------------------------------------------------------ scoreboard
  int checks;
  int errors;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic idle_inputs();
    m_req = 1'b0; m_we = 1'b0; m_addr = 64'd0; m_wdata = 64'd0;
    f_req = 1'b0; f_addr = 64'd0;
  endtask

  // One transaction on one port; cycle 0 is the first cycle req is visible.
  task automatic run_txn(input bit pf, input bit we, input logic [63:0] addr,
                         input logic [63:0] wd, input int drop_at,
                         output int done_k, output logic [63:0] rd, output logic er,
                         output int ren, output int wen, output int stall,
                         output int other, output logic [63:0] wd_seen,
                         output int addr_bad);
    done_k = -1; rd = 64'd0; er = 1'b0; ren = 0; wen = 0; stall = 0;
    other = 0; wd_seen = 64'd0; addr_bad = 0;
    @(posedge clk); #1;
    if (pf) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_r_en_o) ren++;
      if (ram_w_en_o) begin wen++; wd_seen = ram_wdata_o; end
      if ((ram_r_en_o || ram_w_en_o) && ram_addr_o !== addr) addr_bad++;
      if (pf ? f_stall_o : m_stall_o) stall++;
      if (pf ? m_done_o : f_done_o) other++;
      if (pf ? f_done_o : m_done_o) begin
        done_k = k;
        rd = pf ? f_rdata_o : m_rdata_o;
        er = pf ? f_error_o : m_error_o;
        break;
      end
      @(posedge clk); #1;
      if (k + 1 == drop_at) begin
        // Drop the request and scramble fields; neither may disturb the access.
        m_req = 1'b0; f_req = 1'b0;
        m_addr = ~addr; f_addr = ~addr; m_wdata = ~wd; m_we = ~we;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    bit          port_f;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          exp_err;
    logic [63:0] exp_rdata;
    int          exp_done;
    int          exp_ren;
    int          exp_wen;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // ------------------------------------------------------------ random model
  function automatic logic [63:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return MAXA;
      1: return MAXA + 64'd1;
      2: return 64'(MB);
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return {$urandom, $urandom};
      default: return 64'h200 + 64'(8 * $urandom_range(0, 15));
    endcase
  endfunction

  logic [63:0] mdl_mem [0:MB/8-1];

  // ------------------------------------------------------------ main test
  initial begin
    int          dk, rn, wn, st, ot, ab;
    logic [63:0] rd, wds;
    logic        er;
    int          md, fd, fst;
    logic [63:0] mrd, frd;

    checks = 0; errors = 0;
    pre_en = 1'b0; pre_addr = 64'd0; pre_data = 64'd0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_m_done", m_done_o, 1'b0);
    chk("reset_ren", ram_r_en_o, 1'b0);
    chk("reset_addr", ram_addr_o, 64'd0);
    rst = 1'b0;

    // Preload RAM[0x40]
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = 64'h40; pre_data = 64'h1122334455667788;
    @(posedge clk); #1;
    pre_en = 1'b0;

    // ---- table-driven single transactions
    vecs[0] = '{0, 0, 64'h40,  64'd0, 0, 64'h1122334455667788, L+1, L, 0};
    vecs[1] = '{0, 1, 64'h80,  64'hDEADBEEF, 0, 64'd0, L+1, 0, 1};
    vecs[2] = '{0, 0, 64'h80,  64'd0, 0, 64'hDEADBEEF, L+1, L, 0};
    vecs[3] = '{1, 0, 64'h40,  64'd0, 0, 64'h1122334455667788, L+1, L, 0};
    vecs[4] = '{0, 0, MAXA,    64'd0, 0, 64'd0, L+1, L, 0};
    vecs[5] = '{0, 0, MAXA+1,  64'd0, 1, 64'd0, 1, 0, 0};
    vecs[6] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 64'd0, 1, 0, 0};
    vecs[7] = '{0, 1, 64'(MB), 64'h5555, 1, 64'd0, 1, 0, 0};
    vecs[8] = '{0, 1, MAXA,    64'h0123456789ABCDEF, 0, 64'd0, L+1, 0, 1};
    vecs[9] = '{1, 0, MAXA,    64'd0, 0, 64'h0123456789ABCDEF, L+1, L, 0};

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].port_f, vecs[i].we, vecs[i].addr, vecs[i].wdata, -1,
              dk, rd, er, rn, wn, st, ot, wds, ab);
      chk($sformatf("v%0d_done_cycle", i), 64'(dk), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("v%0d_ren_cycles", i), 64'(rn), 64'(vecs[i].exp_ren));
      chk($sformatf("v%0d_wen_cycles", i), 64'(wn), 64'(vecs[i].exp_wen));
      chk($sformatf("v%0d_stall_cycles", i), 64'(st), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_other_done", i), 64'(ot), 64'd0);
      chk($sformatf("v%0d_ram_addr", i), 64'(ab), 64'd0);
      if (vecs[i].exp_wen != 0) chk($sformatf("v%0d_wdata", i), wds, vecs[i].wdata);
    end

    // ---- conflict: both request in cycle 0
    md = -1; fd = -1; fst = 0; mrd = 64'd0; frd = 64'd0;
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h40; f_req = 1'b1; f_addr = 64'h80;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (f_stall_o) fst++;
      if (m_done_o) begin md = k; mrd = m_rdata_o; end
      if (f_done_o) begin fd = k; frd = f_rdata_o; break; end
      @(posedge clk); #1;
      if (md == k) m_req = 1'b0;
    end
    @(posedge clk); #1;
    idle_inputs();
    chk("conflict_m_done_cycle", 64'(md), 64'(L + 1));
    chk("conflict_f_done_cycle", 64'(fd), 64'(2 * L + 3));
    chk("conflict_f_stall_cycles", 64'(fst), 64'(2 * L + 3));
    chk("conflict_m_rdata", mrd, 64'h1122334455667788);
    chk("conflict_f_rdata", frd, 64'hDEADBEEF);

    // ---- request dropped in cycle 1 of a read
    run_txn(0, 0, 64'h40, 64'd0, 1, dk, rd, er, rn, wn, st, ot, wds, ab);
    chk("drop_done_cycle", 64'(dk), 64'(L + 1));
    chk("drop_rdata", rd, 64'h1122334455667788);
    chk("drop_ren_cycles", 64'(rn), 64'(L));

    // ---- reset in the middle of ACCESS
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h40;
    @(posedge clk); #2;
    chk("midrst_pre_busy", busy_o, 1'b1);
    chk("midrst_pre_ren", ram_r_en_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_ren", ram_r_en_o, 1'b0);
    chk("midrst_addr", ram_addr_o, 64'd0);
    chk("midrst_m_done", m_done_o, 1'b0);
    chk("midrst_m_stall", m_stall_o, 1'b1);
    chk("midrst_f_stall", f_stall_o, 1'b0);
    m_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_no_done", m_done_o | f_done_o, 1'b0);
      chk("postrst_idle", busy_o, 1'b0);
    end
    // RAM model was cleared by the reset.
    run_txn(0, 0, 64'h40, 64'd0, -1, dk, rd, er, rn, wn, st, ot, wds, ab);
    chk("postrst_done_cycle", 64'(dk), 64'(L + 1));
    chk("postrst_rdata", rd, 64'd0);

    // ---- randomized traffic against a transaction-timing model
    begin
      longint      g, dc;
      bit          gf, gwe, gerr;
      logic [63:0] gaddr, gwd, grd;
      bit          exp_done, acc, dm, dfe;
      int          m_gap, f_gap;
      bit          n_m_req, n_m_we, n_f_req;
      logic [63:0] n_m_addr, n_m_wdata, n_f_addr;

      for (int i = 0; i < MB/8; i++) mdl_mem[i] = 64'd0;
      g = -100; dc = -100; gf = 0; gwe = 0; gerr = 0;
      gaddr = 64'd0; gwd = 64'd0; grd = 64'd0;
      m_gap = 0; f_gap = 1;
      n_m_req = 0; n_m_we = 0; n_m_addr = 64'd0; n_m_wdata = 64'd0;
      n_f_req = 0; n_f_addr = 64'd0;

      for (int t = 0; t < 1500; t++) begin
        @(posedge clk); #1;
        m_req = n_m_req; m_we = n_m_we; m_addr = n_m_addr; m_wdata = n_m_wdata;
        f_req = n_f_req; f_addr = n_f_addr;
        @(negedge clk);

        exp_done = (t == dc);
        acc = !gerr && (t > g) && (t <= g + L);
        dm  = exp_done && !gf;
        dfe = exp_done && gf;
        chk("rnd_m_done", m_done_o, dm);
        chk("rnd_f_done", f_done_o, dfe);
        chk("rnd_m_rdata", m_rdata_o, dm ? grd : 64'd0);
        chk("rnd_f_rdata", f_rdata_o, dfe ? grd : 64'd0);
        chk("rnd_m_err", m_error_o, dm && gerr);
        chk("rnd_f_err", f_error_o, dfe && gerr);
        chk("rnd_ren", ram_r_en_o, acc && !gwe);
        chk("rnd_wen", ram_w_en_o, acc && gwe && (t == g + 1));
        chk("rnd_ram_addr", ram_addr_o, acc ? gaddr : 64'd0);
        if (acc && gwe && (t == g + 1)) chk("rnd_ram_wdata", ram_wdata_o, gwd);
        chk("rnd_busy", busy_o, (t > g) && (t <= dc));
        chk("rnd_m_stall", m_stall_o, m_req && !dm);
        chk("rnd_f_stall", f_stall_o, f_req && !dfe);

        // Grant decision for this idle cycle.
        if (t > dc && (m_req || f_req)) begin
          gf    = !m_req;
          gwe   = m_req ? m_we : 1'b0;
          gaddr = m_req ? m_addr : f_addr;
          gwd   = m_wdata;
          gerr  = gaddr > MAXA;
          g     = t;
          dc    = gerr ? t + 1 : t + L + 1;
          if (gerr || gwe) grd = 64'd0;
          else grd = mdl_mem[gaddr[9:3]];
          if (!gerr && gwe) mdl_mem[gaddr[9:3]] = gwd;
          exp_q.push_back(grd);
        end

        // Requesters: hold until done, then idle for a random gap.
        if (dm) begin
          n_m_req = 0; m_gap = $urandom_range(0, 3);
        end else if (!n_m_req) begin
          if (m_gap == 0) begin
            n_m_req = 1; n_m_we = $urandom_range(0, 1) == 1;
            n_m_addr = pick_addr(); n_m_wdata = {$urandom, $urandom};
          end else m_gap--;
        end
        if (dfe) begin
          n_f_req = 0; f_gap = $urandom_range(0, 3);
        end else if (!n_f_req) begin
          if (f_gap == 0) begin
            n_f_req = 1; n_f_addr = pick_addr();
          end else f_gap--;
        end
      end
      @(posedge clk); #1;
      idle_inputs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
